// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Hits complete in the request cycle; misses optionally write back the dirty
// victim, then fill the line from backing memory and retry as a hit.
module l1_dcache #(
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t state;

    logic [255:0]       line_data  [NUM_SETS];
    logic [TAG_W-1:0]   line_tag   [NUM_SETS];
    logic [NUM_SETS-1:0] line_valid;
    logic [NUM_SETS-1:0] line_dirty;

    // Line address of the outstanding miss; the CPU may drop or change its
    // request while the miss is serviced, so the fill target is held here.
    logic [26:0]        miss_line;
    logic [IDX_W-1:0]   miss_idx;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         req_off;
    logic               req;
    logic               hit;
    logic               addr_unused;

    assign req_idx     = mem_address[5 +: IDX_W];
    assign req_tag     = mem_address[31 -: TAG_W];
    assign req_off     = mem_address[4:2];
    assign miss_idx    = miss_line[IDX_W-1:0];
    assign addr_unused = ^mem_address[1:0];

    assign req = mem_read | mem_write;
    assign hit = req && line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    // Byte-lane merge of store data into an existing word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // Output decode from the registered state; everything is forced low during reset.
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        if (mem_read && !mem_write) begin
                            mem_rdata = line_data[req_idx][{req_off, 5'b0} +: 32];
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {line_tag[miss_idx], miss_idx, 5'b0};
                    pmem_wdata   = line_data[miss_idx];
                end
                FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {miss_line, 5'b0};
                end
                default: ;
            endcase
        end
    end

    // Control FSM with valid/dirty bookkeeping; the only reset state in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_valid <= '0;
            line_dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (mem_write) line_dirty[req_idx] <= 1'b1;
                    end else if (req) begin
                        state <= (line_valid[req_idx] && line_dirty[req_idx]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        line_dirty[miss_idx] <= 1'b0;
                        state                <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        line_valid[miss_idx] <= 1'b1;
                        line_dirty[miss_idx] <= 1'b0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data/tag arrays and miss address: no reset, writes gated by the control state.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && req && !hit) begin
            miss_line <= mem_address[31:5];
        end
        if (mem_resp && mem_write) begin
            line_data[req_idx][{req_off, 5'b0} +: 32] <=
                merge_word(line_data[req_idx][{req_off, 5'b0} +: 32], mem_wdata, mem_byte_enable);
        end
        if (!rst && state == FILL && pmem_resp) begin
            line_data[miss_idx] <= pmem_rdata;
            line_tag[miss_idx]  <= miss_line[26 -: TAG_W];
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache (NUM_SETS = 8) with a backing-memory responder.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp, pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp;
    logic         resp_model  = 1'b0;
    logic         inject_resp = 1'b0;

    assign pmem_resp = resp_model | inject_resp;

    int vectors = 0, miscompares = 0;
    int resp_delay = 1, wait_cnt = 0;
    int fill_cnt = 0, wb_cnt = 0, resp_cnt = 0, bad_cnt = 0;
    logic [31:0]  fill_addr = '0, wb_addr = '0;
    logic [255:0] fill_line = '0, wb_data = '0;

    l1_dcache #(.NUM_SETS(8)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // Backing memory: answers each request after resp_delay visible cycles.
    always begin
        @(posedge clk);
        #2;
        if (resp_model) begin
            resp_model = 1'b0;
            wait_cnt   = 0;
        end
        if (pmem_read || pmem_write) begin
            wait_cnt++;
            if (wait_cnt >= resp_delay) begin
                resp_model = 1'b1;
                if (pmem_read) begin
                    pmem_rdata = fill_line;
                    fill_addr  = pmem_address;
                    fill_cnt++;
                end else begin
                    wb_addr = pmem_address;
                    wb_data = pmem_wdata;
                    wb_cnt++;
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Edge-sampled protocol observation.
    always @(posedge clk) begin
        if (mem_resp) resp_cnt++;
        if ((mem_resp && (pmem_read || pmem_write)) || (pmem_read && pmem_write)) bad_cnt++;
    end

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + k;
        return l;
    endfunction

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             output int cycles, output logic [31:0] rdata, output logic ok);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        ok = 1'b0; cycles = -1; rdata = '0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (mem_resp) begin
                ok = 1'b1; cycles = i; rdata = mem_rdata;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0; mem_address = '0; mem_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (mem_resp !== 1'b0) begin miscompares++; $display("FAIL rst_mem_resp got %b want 0", mem_resp); end
        vectors++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin miscompares++; $display("FAIL rst_pmem_rw got %b%b want 00", pmem_read, pmem_write); end
        vectors++; if (pmem_address !== 32'h0) begin miscompares++; $display("FAIL rst_pmem_addr got %h want 0", pmem_address); end
        vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_rdata got %h want 0", mem_rdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'h0 || pmem_wdata !== '0) begin
            miscompares++; $display("FAIL post_rst_outputs got %b%b%b %h want 000 0", mem_resp, pmem_read, pmem_write, pmem_address);
        end
    endtask

    task automatic test_cold_read();
        int cyc, f0, w0, r0; logic [31:0] rd; logic ok;
        resp_delay = 5; fill_line = make_line(32'hDEAD_BEEE);
        f0 = fill_cnt; w0 = wb_cnt; r0 = resp_cnt;
        do_access(1'b1, 1'b0, 32'h0000_0104, '0, '0, cyc, rd, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL cold_resp got %b want 1", ok); end
        vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL cold_rdata got %h want deadbeef", rd); end
        vectors++; if (cyc != 6) begin miscompares++; $display("FAIL cold_latency got %0d want 6", cyc); end
        vectors++; if (fill_cnt - f0 != 1 || fill_addr !== 32'h0000_0100) begin miscompares++; $display("FAIL cold_fill got %0d@%h want 1@00000100", fill_cnt - f0, fill_addr); end
        vectors++; if (wb_cnt != w0) begin miscompares++; $display("FAIL cold_no_wb got %0d want 0", wb_cnt - w0); end
        vectors++; if (resp_cnt - r0 != 1) begin miscompares++; $display("FAIL cold_resp_count got %0d want 1", resp_cnt - r0); end
    endtask

    task automatic test_write_hit();
        int cyc, f0; logic [31:0] rd; logic ok;
        f0 = fill_cnt;
        do_access(1'b0, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0011, cyc, rd, ok);
        vectors++; if (ok !== 1'b1 || cyc != 0) begin miscompares++; $display("FAIL whit_latency got %b/%0d want 1/0", ok, cyc); end
        do_access(1'b1, 1'b0, 32'h0000_0104, '0, '0, cyc, rd, ok);
        vectors++; if (rd !== 32'hDEAD_3344 || cyc != 0) begin miscompares++; $display("FAIL whit_merge got %h/%0d want dead3344/0", rd, cyc); end
        do_access(1'b0, 1'b1, 32'h0000_0108, 32'hFFFF_FFFF, 4'b0000, cyc, rd, ok);
        vectors++; if (ok !== 1'b1 || cyc != 0) begin miscompares++; $display("FAIL whit_be0_resp got %b/%0d want 1/0", ok, cyc); end
        do_access(1'b1, 1'b0, 32'h0000_0108, '0, '0, cyc, rd, ok);
        vectors++; if (rd !== 32'hDEAD_BEF0) begin miscompares++; $display("FAIL whit_be0_data got %h want deadbef0", rd); end
        vectors++; if (fill_cnt != f0) begin miscompares++; $display("FAIL whit_no_fill got %0d want 0", fill_cnt - f0); end
    endtask

    task automatic test_writeback();
        int cyc, f0, w0; logic [31:0] rd; logic ok;
        resp_delay = 3; fill_line = make_line(32'hCAFE_0000);
        f0 = fill_cnt; w0 = wb_cnt;
        do_access(1'b1, 1'b0, 32'h0000_0904, '0, '0, cyc, rd, ok);
        vectors++; if (ok !== 1'b1 || rd !== 32'hCAFE_0001) begin miscompares++; $display("FAIL wb_rdata got %b/%h want 1/cafe0001", ok, rd); end
        vectors++; if (cyc != 7) begin miscompares++; $display("FAIL wb_latency got %0d want 7", cyc); end
        vectors++; if (wb_cnt - w0 != 1 || wb_addr !== 32'h0000_0100) begin miscompares++; $display("FAIL wb_addr got %0d@%h want 1@00000100", wb_cnt - w0, wb_addr); end
        vectors++; if (wb_data[95:0] !== {32'hDEAD_BEF0, 32'hDEAD_3344, 32'hDEAD_BEEE}) begin
            miscompares++; $display("FAIL wb_data got %h want deadbef0dead3344deadbeee", wb_data[95:0]);
        end
        vectors++; if (fill_cnt - f0 != 1 || fill_addr !== 32'h0000_0900) begin miscompares++; $display("FAIL wb_fill got %0d@%h want 1@00000900", fill_cnt - f0, fill_addr); end
    endtask

    task automatic test_clean_miss();
        int cyc, f0, w0, r0; logic [31:0] rd; logic ok;
        resp_delay = 2; fill_line = make_line(32'h5A5A_0000);
        f0 = fill_cnt; w0 = wb_cnt; r0 = resp_cnt;
        do_access(1'b1, 1'b0, 32'h0000_1104, '0, '0, cyc, rd, ok);
        vectors++; if (rd !== 32'h5A5A_0001 || cyc != 3) begin miscompares++; $display("FAIL clean_rdata got %h/%0d want 5a5a0001/3", rd, cyc); end
        vectors++; if (wb_cnt != w0) begin miscompares++; $display("FAIL clean_no_wb got %0d want 0", wb_cnt - w0); end
        vectors++; if (fill_cnt - f0 != 1 || fill_addr !== 32'h0000_1100) begin miscompares++; $display("FAIL clean_fill got %0d@%h want 1@00001100", fill_cnt - f0, fill_addr); end
        vectors++; if (resp_cnt - r0 != 1) begin miscompares++; $display("FAIL clean_resp_count got %0d want 1", resp_cnt - r0); end
    endtask

    task automatic test_read_write_both();
        int cyc; logic [31:0] rd; logic ok;
        do_access(1'b1, 1'b1, 32'h0000_110C, 32'h0BAD_F00D, 4'b1111, cyc, rd, ok);
        vectors++; if (ok !== 1'b1 || cyc != 0) begin miscompares++; $display("FAIL rw_resp got %b/%0d want 1/0", ok, cyc); end
        do_access(1'b1, 1'b0, 32'h0000_110C, '0, '0, cyc, rd, ok);
        vectors++; if (rd !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL rw_as_write got %h want 0badf00d", rd); end
    endtask

    task automatic test_reset_mid_fill();
        int cyc, f0; logic [31:0] rd; logic ok;
        resp_delay = 20; fill_line = make_line(32'h7777_0000);
        f0 = fill_cnt;
        @(negedge clk);
        mem_read = 1'b1; mem_address = 32'h0000_2020;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_2020) begin miscompares++; $display("FAIL rstfill_in_fill got %b@%h want 1@00002020", pmem_read, pmem_address); end
        rst = 1'b1; mem_read = 1'b0; mem_address = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin miscompares++; $display("FAIL rstfill_abort got %b@%h want 0@00000000", pmem_read, pmem_address); end
        repeat (25) @(negedge clk);
        vectors++; if (fill_cnt != f0) begin miscompares++; $display("FAIL rstfill_no_install got %0d want 0", fill_cnt - f0); end
        resp_delay = 2;
        do_access(1'b1, 1'b0, 32'h0000_2020, '0, '0, cyc, rd, ok);
        vectors++; if (cyc != 3 || fill_cnt - f0 != 1 || rd !== 32'h7777_0000) begin
            miscompares++; $display("FAIL rstfill_remiss got %0d/%0d/%h want 3/1/77770000", cyc, fill_cnt - f0, rd);
        end
    endtask

    task automatic test_drop_mid_fill();
        int cyc, f0, w0, r0; logic [31:0] rd; logic ok;
        resp_delay = 6; fill_line = make_line(32'hABCD_0000);
        f0 = fill_cnt; w0 = wb_cnt; r0 = resp_cnt;
        @(negedge clk);
        mem_read = 1'b1; mem_address = 32'h0000_3008;
        repeat (2) @(negedge clk);
        mem_read = 1'b0; mem_address = 32'h0000_0FF0;
        for (int i = 0; i < 30; i++) begin
            if (fill_cnt != f0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        mem_address = '0;
        #1;
        vectors++; if (fill_cnt - f0 != 1 || fill_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL drop_fill got %0d@%h want 1@00003000", fill_cnt - f0, fill_addr); end
        vectors++; if (resp_cnt != r0 || pmem_read !== 1'b0 || wb_cnt != w0) begin
            miscompares++; $display("FAIL drop_quiet got resp %0d rd %b wb %0d want 0 0 0", resp_cnt - r0, pmem_read, wb_cnt - w0);
        end
        do_access(1'b1, 1'b0, 32'h0000_3008, '0, '0, cyc, rd, ok);
        vectors++; if (ok !== 1'b1 || cyc != 0 || rd !== 32'hABCD_0002) begin miscompares++; $display("FAIL drop_reissue got %b/%0d/%h want 1/0/abcd0002", ok, cyc, rd); end
        vectors++; if (fill_cnt - f0 != 1) begin miscompares++; $display("FAIL drop_no_refill got %0d want 1", fill_cnt - f0); end
    endtask

    task automatic test_pmem_resp_idle();
        int cyc; logic [31:0] rd; logic ok;
        @(negedge clk);
        inject_resp = 1'b1;
        @(negedge clk);
        inject_resp = 1'b0;
        #1;
        vectors++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
            miscompares++; $display("FAIL idle_resp_outputs got %b%b%b want 000", pmem_read, pmem_write, mem_resp);
        end
        do_access(1'b1, 1'b0, 32'h0000_3008, '0, '0, cyc, rd, ok);
        vectors++; if (cyc != 0 || rd !== 32'hABCD_0002) begin miscompares++; $display("FAIL idle_resp_hit got %0d/%h want 0/abcd0002", cyc, rd); end
    endtask

    task automatic test_protocol();
        vectors++; if (bad_cnt != 0) begin miscompares++; $display("FAIL protocol_overlap got %0d want 0", bad_cnt); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_writeback();
        test_clean_miss();
        test_read_write_both();
        test_reset_mid_fill();
        test_drop_mid_fill();
        test_pmem_resp_idle();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
